// File: rtl/dec_timer16.sv
// dec_timer16 -- loadable countdown timer with prescaler and auto-reload.
//
// The count is decremented once every (prescale+1) clocks while the timer
// is running. When it reaches terminal count, the timer either stops or
// reloads, and it emits a one-cycle done pulse.
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high, highest priority
//   load         strobe: capture load_val (into count as well when idle)
//   load_val     value to count down from
//   prescale     clocks per decrement minus one, latched on an accepted start
//   start        strobe: begin or resume counting
//   stop         strobe: pause counting (wins over start and over a tick)
//   auto_reload  1 = reload from reload_reg at terminal count and keep running
//   count        current count (registered)
//   busy         1 while running (registered)
//   done         one-cycle pulse at terminal count (registered)
module dec_timer16 #(
  parameter int WIDTH = 16,
  parameter int PW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PW-1:0]    prescale,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] reload_reg, reload_d;
  logic [PW-1:0]    ps_lat, ps_d;
  logic [PW-1:0]    pc, pc_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] eff_count;
  logic             done_d;
  logic             tick;

  // Terminal count covers both 0 and 1, so the counter can never wrap
  // from 0 to all-ones (0 only occurs in RUN when reload_reg is 0).
  function automatic logic is_terminal(input logic [WIDTH-1:0] c);
    return (c[WIDTH-1:1] == '0);
  endfunction

  assign tick = (pc == ps_lat);

  always_comb begin
    state_d   = state;
    reload_d  = reload_reg;
    ps_d      = ps_lat;
    pc_d      = pc;
    count_d   = count;
    done_d    = 1'b0;
    eff_count = count;

    case (state)
      IDLE: begin
        if (!stop) begin
          // A same-cycle load is applied first, so start sees load_val.
          if (load) begin
            reload_d  = load_val;
            count_d   = load_val;
            eff_count = load_val;
          end
          if (start) begin
            if (eff_count != '0) begin
              state_d = RUN;
              ps_d    = prescale;
              pc_d    = '0;
            end else begin
              done_d = 1'b1;
            end
          end
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
          pc_d    = '0;
        end else begin
          // load while running only stages the next reload value.
          if (load) begin
            reload_d = load_val;
          end
          if (tick) begin
            pc_d = '0;
            if (!is_terminal(count)) begin
              count_d = count - 1'b1;
            end else begin
              done_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_reg;
              end else begin
                count_d = '0;
                state_d = IDLE;
              end
            end
          end else begin
            pc_d = pc + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      ps_lat     <= '0;
      pc         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      count      <= count_d;
      reload_reg <= reload_d;
      ps_lat     <= ps_d;
      pc         <= pc_d;
      busy       <= (state_d == RUN);
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_dec_timer16.sv
// tb_dec_timer16 -- directed-vector scoreboard bench for dec_timer16.
// The driver applies one vector per clock and queues the outputs expected
// after that edge; an independent monitor pops and compares each cycle.
module tb_dec_timer16;

  logic        clk = 1'b0;
  logic        reset, load, start, stop, auto_reload;
  logic [15:0] load_val;
  logic [7:0]  prescale;
  logic [15:0] count;
  logic        busy, done;

  typedef struct {
    logic [15:0] cnt;
    logic        bsy;
    logic        dn;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dec_timer16 #(.WIDTH(16), .PW(8)) dut (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val),
    .prescale(prescale), .start(start), .stop(stop),
    .auto_reload(auto_reload), .count(count), .busy(busy), .done(done)
  );

  // Monitor: outputs are registered, so one expectation per edge.
  always @(posedge clk) begin
    exp_t e;
    #3;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (count !== e.cnt) begin
        errors++;
        $display("FAIL %s count: got %h expected %h", e.name, count, e.cnt);
      end
      checks++;
      if (busy !== e.bsy) begin
        errors++;
        $display("FAIL %s busy: got %b expected %b", e.name, busy, e.bsy);
      end
      checks++;
      if (done !== e.dn) begin
        errors++;
        $display("FAIL %s done: got %b expected %b", e.name, done, e.dn);
      end
    end
  end

  // Apply one vector for one clock and queue the post-edge expectation.
  task automatic cyc(input logic rst, input logic ld, input logic [15:0] lv,
                     input logic [7:0] ps, input logic st, input logic sp,
                     input logic ar, input logic [15:0] ec, input logic eb,
                     input logic ed, input string nm);
    exp_t e;
    reset = rst; load = ld; load_val = lv; prescale = ps;
    start = st; stop = sp; auto_reload = ar;
    e.cnt = ec; e.bsy = eb; e.dn = ed; e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Idle cycle with only auto_reload driven.
  task automatic idle(input logic ar, input logic [15:0] ec, input logic eb,
                      input logic ed, input string nm);
    cyc(0, 0, 16'h0, 8'h0, 0, 0, ar, ec, eb, ed, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; load = 0; load_val = 0; prescale = 0;
    start = 0; stop = 0; auto_reload = 0;

    cyc(1, 0, 16'h0, 8'h0, 0, 0, 0, 16'd0, 0, 0, "reset");

    // load 3, prescale 0
    cyc(0, 1, 16'd3, 8'h0, 0, 0, 0, 16'd3, 0, 0, "t1_load");
    cyc(0, 0, 16'h0, 8'd0, 1, 0, 0, 16'd3, 1, 0, "t1_start");
    idle(0, 16'd2, 1, 0, "t1_c1");
    idle(0, 16'd1, 1, 0, "t1_c2");
    idle(0, 16'd0, 0, 1, "t1_term");
    idle(0, 16'd0, 0, 0, "t1_after");

    // load 2, prescale 3
    cyc(0, 1, 16'd2, 8'h0, 0, 0, 0, 16'd2, 0, 0, "t2_load");
    cyc(0, 0, 16'h0, 8'd3, 1, 0, 0, 16'd2, 1, 0, "t2_start");
    for (int i = 1; i <= 3; i++) idle(0, 16'd2, 1, 0, "t2_wait1");
    idle(0, 16'd1, 1, 0, "t2_step4");
    for (int i = 5; i <= 7; i++) idle(0, 16'd1, 1, 0, "t2_wait2");
    idle(0, 16'd0, 0, 1, "t2_step8");
    idle(0, 16'd0, 0, 0, "t2_after");

    // load 5, stop at 3, resume
    cyc(0, 1, 16'd5, 8'h0, 0, 0, 0, 16'd5, 0, 0, "t3_load");
    cyc(0, 0, 16'h0, 8'd0, 1, 0, 0, 16'd5, 1, 0, "t3_start");
    idle(0, 16'd4, 1, 0, "t3_c1");
    idle(0, 16'd3, 1, 0, "t3_c2");
    cyc(0, 0, 16'h0, 8'h0, 0, 1, 0, 16'd3, 0, 0, "t3_stop");
    for (int i = 0; i < 4; i++) idle(0, 16'd3, 0, 0, "t3_held");
    cyc(0, 0, 16'h0, 8'd0, 1, 0, 0, 16'd3, 1, 0, "t3_resume");
    idle(0, 16'd2, 1, 0, "t3_r1");
    idle(0, 16'd1, 1, 0, "t3_r2");
    idle(0, 16'd0, 0, 1, "t3_term");

    // auto-reload with 2, then stage a new reload value of 4 while running
    cyc(0, 1, 16'd2, 8'h0, 0, 0, 1, 16'd2, 0, 0, "t4_load");
    cyc(0, 0, 16'h0, 8'd0, 1, 0, 1, 16'd2, 1, 0, "t4_start");
    for (int i = 0; i < 3; i++) begin
      idle(1, 16'd1, 1, 0, "t4_odd");
      idle(1, 16'd2, 1, 1, "t4_reload");
    end
    cyc(0, 1, 16'd4, 8'h0, 0, 0, 1, 16'd1, 1, 0, "t4_run_load");
    idle(1, 16'd4, 1, 1, "t4_new_reload");
    cyc(0, 0, 16'h0, 8'h0, 0, 1, 1, 16'd4, 0, 0, "t4_stop");

    // zero-count start, start+stop together
    cyc(0, 1, 16'd0, 8'h0, 0, 0, 0, 16'd0, 0, 0, "t5_load0");
    cyc(0, 0, 16'h0, 8'h0, 1, 0, 0, 16'd0, 0, 1, "t5_zero_start");
    idle(0, 16'd0, 0, 0, "t5_after");
    cyc(0, 1, 16'd6, 8'h0, 0, 0, 0, 16'd6, 0, 0, "t5_load6");
    cyc(0, 0, 16'h0, 8'h0, 1, 1, 0, 16'd6, 0, 0, "t5_start_stop");

    // load and start together: start sees load_val
    cyc(0, 1, 16'd1, 8'h0, 1, 0, 0, 16'd1, 1, 0, "t6_load_start");
    idle(0, 16'd0, 0, 1, "t6_term");

    // load FFFF, run 10 cycles, reset mid-count
    cyc(0, 1, 16'hFFFF, 8'h0, 0, 0, 0, 16'hFFFF, 0, 0, "t7_load");
    cyc(0, 0, 16'h0, 8'd0, 1, 0, 0, 16'hFFFF, 1, 0, "t7_start");
    for (int i = 1; i <= 10; i++)
      idle(0, 16'hFFFF - 16'(i), 1, 0, "t7_run");
    cyc(1, 0, 16'h0, 8'h0, 0, 0, 0, 16'd0, 0, 0, "t7_reset");
    cyc(0, 0, 16'h0, 8'h0, 1, 0, 0, 16'd0, 0, 1, "t7_start_a");
    idle(0, 16'd0, 0, 0, "t7_gap");
    cyc(0, 0, 16'h0, 8'h0, 1, 0, 0, 16'd0, 0, 1, "t7_start_b");
    idle(0, 16'd0, 0, 0, "t7_end");

    // let the monitor drain the queue, bounded
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_timer16.md
# dec_timer16

Loadable 16-bit countdown timer for the CPU-on-FPGA datapath. It is the decrementing counterpart of the ALU incrementor: it counts a value down to zero instead of up. It supports a programmable clock prescaler, a start/stop handshake, an optional auto-reload mode, and a one-cycle `done` pulse. It sits beside the PC and ALU as a delay/loop timer that the CPU or test harness programs through simple strobes.

## Interface
- `WIDTH`, 16: counter and reload width.
- `PW`, 8: prescaler width.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; highest priority.
- `load`  in  1  strobe: capture `load_val`.
- `load_val`  in  WIDTH  value to count down from.
- `prescale`  in  PW  ticks = `prescale`+1 clocks per decrement; latched on an accepted `start`.
- `start`  in  1  strobe: begin or resume counting.
- `stop`  in  1  strobe: pause counting.
- `auto_reload`  in  1  1 = reload and keep running at terminal count; sampled live.
- `count`  out  WIDTH  current count (registered).
- `busy`  out  1  1 while in RUN (registered).
- `done`  out  1  one-cycle pulse at terminal count (registered).

## Operation
- Internal registers:
  - `reload_reg` [WIDTH]
  - `ps_lat` [PW]: latched prescale
  - `pc` [PW]: prescaler count
  - state register: IDLE or RUN
- Reset values: `count`=0, `reload_reg`=0, `ps_lat`=0, `pc`=0, `busy`=0, `done`=0, state=IDLE.
- `done` defaults to 0 every cycle unless set by a rule below.
- IDLE, priority from highest to lowest:
  1. `stop`: no action. `start`+`stop` together equals `stop`.
  2. `load`: `reload_reg`<=`load_val`, `count`<=`load_val`.
  3. `start` with `count`≠0: state<=RUN, `ps_lat`<=`prescale`, `pc`<=0.
  4. `start` with `count`==0: `done`<=1, stay IDLE.
- When `load` and `start` arrive in the same cycle, the load is applied first and `start` is evaluated against `load_val`.
- RUN, priority from highest to lowest:
  1. `stop`: state<=IDLE, `count` and `reload_reg` held, `pc`<=0, no `done`.
     - A later `start` resumes from the held `count`.
     - `stop` beats a same-cycle tick.
  2. A tick occurs when `pc`==`ps_lat`. On a tick, `pc`<=0. Otherwise `pc`<=`pc`+1 and `count` is held.
  3. On a non-terminal tick (`count`>1): `count`<=`count`−1.
  4. On a terminal tick (`count`∈{0,1}): `done`<=1, then:
     - with `auto_reload`=0: `count`<=0, state<=IDLE.
     - with `auto_reload`=1: `count`<=`reload_reg`, stay RUN. A `reload_reg` of 0 gives a terminal tick every period.
- `load` in RUN: `reload_reg`<=`load_val` only; `count` is unaffected. It takes effect at the next auto-reload or the next `load` in IDLE.
- `start` in RUN: ignored. `ps_lat` is not relatched.
- Arithmetic is unsigned. `count` never wraps from 0 to `FFFF`, because the terminal check covers 0 and 1.
- `busy` mirrors state==RUN, updated at the same edge as the state.

## Timing
- `start` is sampled at edge E0. `busy`=1 after E0.
- The first decrement happens at edge E0+(P+1), where P=`ps_lat`.
- Terminal count is reached at edge E0+N·(P+1), where N is the start count:
  - `done`=1 for exactly one cycle after that edge.
  - `busy` falls at the same edge (non-auto mode).
- In auto-reload mode, `done` pulses every N·(P+1) cycles with `busy` held at 1. The first period uses the current count; later periods use `reload_reg`.
- Zero-count `start`: `done` pulses after E0, and `busy` stays 0.
- A `reset` asserted mid-count returns every output to its reset value after that edge. No `done` is generated.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then load 3, then start with prescale=0:
  - `count` = 2, 1, 0 on the three edges after start.
  - `done` is a single pulse coincident with `count`=0.
  - `busy` is 1 for exactly 3 cycles.
- Load 2, prescale=3, start:
  - `count` steps at cycles 4 and 8 after start.
  - `done` pulses once after cycle 8.
- Load 5, prescale=0, start; `stop` when `count`=3; idle 4 cycles; start again:
  - `count` holds 3 while stopped, and no `done` pulse occurs.
  - After the restart, `done` arrives 3 cycles later.
- `auto_reload`=1, load 2, prescale=0, start; observe 6 cycles:
  - `count` sequence 1, 2, 1, 2, 1, 2 (the reload replaces the visible 0).
  - `done` pulses at cycles 2, 4, 6.
  - `busy` stays 1 throughout.
- Start with `count`=0 → `done` pulses for one cycle, `busy` stays 0. A `start`+`stop` pair in the same cycle produces no state change.
- Load `FFFF`, start, assert `reset` after 10 cycles:
  - `count`=0, `busy`=0, `done`=0 on the next edge.
  - Subsequent `start` strobes with no load only produce zero-count `done` pulses.
